// File: rtl/mmio_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_master
// Purpose  : MMIO bus master that sits between the CPU data-memory port and
//            up to 16 peripherals. It decodes CPU load/store addresses against
//            a fixed MMIO window and selects one peripheral by region index.
//            It then runs a two-phase (setup/access) transfer with wait states
//            and a timeout, and stalls the CPU until the transfer completes.
//            Unmapped regions inside the window complete at once with an error.
//
// Ports    : clk, reset            clock (rising edge), async active-high reset
//            cpu_req/write/addr/wdata   CPU request side
//            cpu_stall             CPU must hold its request
//            cpu_rdata             registered load data
//            cpu_rvalid, cpu_err   one-cycle completion / error pulses
//            paddr/pwdata/pwrite   latched transfer attributes
//            psel, penable         one-hot select, access phase
//            prdata, pready        per-peripheral read data / ready
//
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_master #(
    parameter int                NUM_PERIPH  = 4,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int                REGION_BITS = 8,
    parameter int                TIMEOUT     = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_write,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_stall,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_rvalid,
    output logic                         cpu_err,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    output logic                         pwrite,
    output logic [NUM_PERIPH-1:0]        psel,
    output logic                         penable,
    input  logic [NUM_PERIPH*DATA_W-1:0] prdata,
    input  logic [NUM_PERIPH-1:0]        pready
);

    // Address bits below this position are the region offset and region
    // index; everything from here up must match the window base.
    localparam int c_TAG_LSB = REGION_BITS + 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state_q;
    logic [3:0]          r_idx_q;
    logic [7:0]          r_cnt_q;
    logic                r_err_q;
    logic [ADDR_W-1:0]   r_paddr_q;
    logic [DATA_W-1:0]   r_pwdata_q;
    logic                r_pwrite_q;
    logic [DATA_W-1:0]   r_rdata_q;

    state_t              w_state_d;
    logic [3:0]          w_idx_d;
    logic [7:0]          w_cnt_d;
    logic                w_err_d;
    logic [ADDR_W-1:0]   w_paddr_d;
    logic [DATA_W-1:0]   w_pwdata_d;
    logic                w_pwrite_d;
    logic [DATA_W-1:0]   w_rdata_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                w_hit;
    logic [3:0]          w_idx;
    logic                w_mapped;
    logic [7:0]          w_cnt_inc;

    assign w_hit     = (cpu_addr[ADDR_W-1:c_TAG_LSB] == MMIO_BASE[ADDR_W-1:c_TAG_LSB]);
    assign w_idx     = cpu_addr[REGION_BITS +: 4];
    // Widened by one bit so NUM_PERIPH = 16 still compares correctly.
    assign w_mapped  = ({1'b0, w_idx} < 5'(NUM_PERIPH));
    assign w_cnt_inc = r_cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Selected-peripheral mux: only the latched index is ever looked at,
    // so ready/data from unselected peripherals cannot affect a transfer.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_sel_ready;
    logic [NUM_PERIPH-1:0] w_psel_oh;

    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        w_psel_oh   = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (r_idx_q == 4'(i)) begin
                w_sel_rdata  = prdata[i*DATA_W +: DATA_W];
                w_sel_ready  = pready[i];
                w_psel_oh[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_cnt_d    = r_cnt_q;
        w_err_d    = r_err_q;
        w_paddr_d  = r_paddr_q;
        w_pwdata_d = r_pwdata_q;
        w_pwrite_d = r_pwrite_q;
        w_rdata_d  = r_rdata_q;

        case (r_state_q)
            S_IDLE: begin
                if (cpu_req && w_hit) begin
                    if (w_mapped) begin
                        w_idx_d    = w_idx;
                        w_paddr_d  = cpu_addr;
                        w_pwdata_d = cpu_wdata;
                        w_pwrite_d = cpu_write;
                        w_state_d  = S_SETUP;
                    end else begin
                        // Unmapped region: complete with an error, no bus cycle.
                        w_err_d   = 1'b1;
                        w_rdata_d = '0;
                        w_state_d = S_DONE;
                    end
                end
            end

            S_SETUP: begin
                w_cnt_d   = 8'd0;
                w_state_d = S_ACCESS;
            end

            S_ACCESS: begin
                if (w_sel_ready) begin
                    if (!r_pwrite_q) begin
                        w_rdata_d = w_sel_rdata;
                    end
                    w_err_d   = 1'b0;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                    // The count is compared after incrementing, so ACCESS
                    // lasts exactly TIMEOUT cycles when pready never rises.
                    if (w_cnt_inc == 8'(TIMEOUT)) begin
                        w_err_d   = 1'b1;
                        w_rdata_d = '0;
                        w_state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The CPU still holds its request this cycle; it must not be
                // re-accepted, so DONE always returns to IDLE.
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_idx_q    <= 4'd0;
            r_cnt_q    <= 8'd0;
            r_err_q    <= 1'b0;
            r_paddr_q  <= '0;
            r_pwdata_q <= '0;
            r_pwrite_q <= 1'b0;
            r_rdata_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_cnt_q    <= w_cnt_d;
            r_err_q    <= w_err_d;
            r_paddr_q  <= w_paddr_d;
            r_pwdata_q <= w_pwdata_d;
            r_pwrite_q <= w_pwrite_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign psel       = ((r_state_q == S_SETUP) || (r_state_q == S_ACCESS)) ? w_psel_oh : '0;
    assign penable    = (r_state_q == S_ACCESS);
    assign cpu_rvalid = (r_state_q == S_DONE);
    assign cpu_err    = (r_state_q == S_DONE) && r_err_q;
    assign cpu_rdata  = r_rdata_q;
    assign paddr      = r_paddr_q;
    assign pwdata     = r_pwdata_q;
    assign pwrite     = r_pwrite_q;

    // The IDLE term depends combinationally on the request, so it is gated
    // with reset to keep stall low while reset is asserted.
    assign cpu_stall  = !reset &&
                        (((r_state_q == S_IDLE) && cpu_req && w_hit) ||
                         (r_state_q == S_SETUP) ||
                         (r_state_q == S_ACCESS));

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bus_master
// Purpose  : Self-checking bench for mmio_bus_master. A table of transactions
//            with hand-computed completion cycle, select, error and read data
//            is replayed back to back; reset behaviour is covered by
//            hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_master;

    localparam int c_NP = 4;
    localparam int c_DW = 32;
    localparam int c_AW = 32;

    logic                   clk;
    logic                   reset;
    logic                   cpu_req;
    logic                   cpu_write;
    logic [c_AW-1:0]        cpu_addr;
    logic [c_DW-1:0]        cpu_wdata;
    logic                   cpu_stall;
    logic [c_DW-1:0]        cpu_rdata;
    logic                   cpu_rvalid;
    logic                   cpu_err;
    logic [c_AW-1:0]        paddr;
    logic [c_DW-1:0]        pwdata;
    logic                   pwrite;
    logic [c_NP-1:0]        psel;
    logic                   penable;
    logic [c_NP*c_DW-1:0]   prdata;
    logic [c_NP-1:0]        pready;

    int n_checks;
    int n_errors;

    mmio_bus_master #(
        .NUM_PERIPH  (c_NP),
        .ADDR_W      (c_AW),
        .DATA_W      (c_DW),
        .MMIO_BASE   (32'hFFFF_0000),
        .REGION_BITS (8),
        .TIMEOUT     (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_err    (cpu_err),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction record. waits < 0 means pready never rises.
    // exp_done is the cycle (request cycle = 0) carrying rvalid; 0 = RAM miss.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rret;
        int          waits;
        int          exp_done;
        logic [3:0]  exp_psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_prdata(input int idx, input logic [31:0] rret);
        for (int i = 0; i < c_NP; i++) begin
            prdata[i*c_DW +: c_DW] = (i == idx) ? rret : (32'hC0DE_0000 | 32'(i));
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        int          idx;
        int          last;
        logic [7:0]  exp_ctrl;
        logic        e_stall;
        logic        e_pen;
        logic        e_rv;
        logic        e_err;
        logic [3:0]  e_psel;
        idx  = int'(v.addr[11:8]);
        last = (v.exp_done == 0) ? 2 : v.exp_done;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            cpu_req   = 1'b1;
            cpu_write = v.write;
            cpu_addr  = v.addr;
            cpu_wdata = v.wdata;
            drive_prdata(idx, v.rret);
            // Unselected peripherals are ready all the time on purpose.
            pready = 4'hF;
            if (idx < c_NP) begin
                pready[idx] = (v.waits >= 0) && (c == 2 + v.waits);
            end
            #1;
            e_stall  = (v.exp_done != 0) && (c < v.exp_done);
            e_psel   = (c >= 1 && c < v.exp_done) ? v.exp_psel : 4'h0;
            e_pen    = (c >= 2 && c < v.exp_done && v.exp_psel != 4'h0);
            e_rv     = (v.exp_done != 0) && (c == v.exp_done);
            e_err    = e_rv && v.exp_err;
            exp_ctrl = {e_stall, e_pen, e_rv, e_err, e_psel};
            chk($sformatf("t%0d c%0d stall/pen/rvalid/err/psel", id, c),
                64'({cpu_stall, penable, cpu_rvalid, cpu_err, psel}), 64'(exp_ctrl));
            if (e_psel != 4'h0) begin
                chk($sformatf("t%0d c%0d paddr/pwrite", id, c),
                    64'({pwrite, paddr}), 64'({v.write, v.addr}));
                if (v.write) begin
                    chk($sformatf("t%0d c%0d pwdata", id, c), 64'(pwdata), 64'(v.wdata));
                end
            end
            if (e_rv || v.exp_done == 0) begin
                chk($sformatf("t%0d c%0d rdata", id, c), 64'(cpu_rdata), 64'(v.exp_rdata));
            end
        end
    endtask

    vec_t vecs [10];
    vec_t post;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 32'hFFFF_0104;
        cpu_wdata = 32'h0;
        pready    = 4'hF;
        drive_prdata(0, 32'h0);

        //         wr    addr           wdata          rret           wt  done psel   err  rdata
        vecs[0] = '{1'b1, 32'hFFFF_0104, 32'h1234_5678, 32'h0,          0,  3, 4'b0010, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'hFFFF_0300, 32'h0,         32'hDEAD_BEEF,  2,  5, 4'b1000, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'hFFFF_0500, 32'h0,         32'h1111_1111,  0,  1, 4'b0000, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'hFFFF_0010, 32'h0,         32'h2222_2222, -1, 17, 4'b0001, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h1000_0000, 32'h0,         32'h3333_3333,  0,  0, 4'b0000, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFF_01FC, 32'h0,         32'hA5A5_0001,  1,  4, 4'b0010, 1'b0, 32'hA5A5_0001};
        vecs[6] = '{1'b1, 32'hFFFF_0200, 32'hCAFE_F00D, 32'h4444_4444,  3,  6, 4'b0100, 1'b0, 32'hA5A5_0001};
        vecs[7] = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h0BAD_F00D, 14, 17, 4'b0001, 1'b0, 32'h0BAD_F00D};
        vecs[8] = '{1'b0, 32'hFFFF_1300, 32'h0,         32'h5555_5555,  0,  0, 4'b0000, 1'b0, 32'h0BAD_F00D};
        vecs[9] = '{1'b0, 32'hFFFF_0F00, 32'h0,         32'h6666_6666,  0,  1, 4'b0000, 1'b1, 32'h0};

        // Reset state with a hitting request present: everything must be 0.
        #3;
        chk("reset outputs",
            64'({cpu_stall, penable, cpu_rvalid, cpu_err, psel, pwrite}),
            64'(0));
        chk("reset data", 64'({paddr, pwdata}), 64'(0));
        chk("reset rdata", 64'(cpu_rdata), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset during the ACCESS phase of a wait-stated read.
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 32'hFFFF_0300;
        pready    = 4'b0111;
        drive_prdata(3, 32'h7777_7777);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort pre-reset psel/penable", 64'({psel, penable}), 64'({4'b1000, 1'b1}));
        reset = 1'b1;
        #1;
        chk("abort outputs",
            64'({cpu_stall, penable, cpu_rvalid, cpu_err, psel, pwrite}), 64'(0));
        chk("abort data", 64'({paddr, pwdata}), 64'(0));
        chk("abort rdata", 64'(cpu_rdata), 64'(0));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        reset   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            chk($sformatf("post-abort idle c%0d", c),
                64'({cpu_stall, penable, cpu_rvalid, cpu_err, psel}), 64'(0));
        end

        post = '{1'b0, 32'hFFFF_0104, 32'h0, 32'h5555_AAAA, 0, 3, 4'b0010, 1'b0, 32'h5555_AAAA};
        run_txn(10, post);

        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(posedge clk);
        #2;
        chk("final idle", 64'({cpu_stall, penable, cpu_rvalid, psel}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
